// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer for a 2**AW x DW data memory that
// writes on posedge and reads on negedge. Port 0 is the pipeline MEM stage
// (stalled via stall0 while pending), port 1 is a DMA/loader. One access per
// cycle at most; read data returns one cycle after issue with a valid pulse.
module dmem_arbiter #(
  parameter int FIXED_PRI = 0,
  parameter int AW        = 8,
  parameter int DW        = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          stall0,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_write,
  output logic          mem_read,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nx;

  logic          iss_port;
  logic          iss_we;
  logic [AW-1:0] iss_addr;
  logic [DW-1:0] iss_wdata;
  logic          rr_last;

  logic          elig0;
  logic          elig1;
  logic          grant;
  logic          win_port;

  // Memory address/data come straight from the issue registers, so they
  // naturally hold their last value while idle.
  assign mem_addr  = iss_addr;
  assign mem_wdata = iss_wdata;

  // Decode the issue state into acks, memory strobes and the pipeline stall.
  always_comb begin
    ack0      = 1'b0;
    ack1      = 1'b0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    if (state == ISSUE) begin
      ack0      = ~iss_port;
      ack1      = iss_port;
      mem_write = iss_we;
      mem_read  = ~iss_we;
    end
    stall0 = req0 & ~ack0;
  end

  // Arbitration: the port being acked this cycle is masked, so its held
  // request is not granted twice for the same command.
  always_comb begin
    elig0    = req0 & ~ack0;
    elig1    = req1 & ~ack1;
    grant    = elig0 | elig1;
    win_port = elig1 & ~elig0;
    if (elig0 && elig1) begin
      win_port = (FIXED_PRI != 0) ? 1'b0 : ~rr_last;
    end
    state_nx = grant ? ISSUE : IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Capture the winning command into the issue registers on every grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_port  <= 1'b0;
      iss_we    <= 1'b0;
      iss_addr  <= '0;
      iss_wdata <= '0;
      rr_last   <= 1'b1;
    end else if (grant) begin
      iss_port  <= win_port;
      iss_we    <= win_port ? we1 : we0;
      iss_addr  <= win_port ? addr1 : addr0;
      iss_wdata <= win_port ? wdata1 : wdata0;
      rr_last   <= win_port;
    end
  end

  // Read return: memory data settles after the issue cycle's negedge and is
  // captured at the closing posedge; reset at that edge drops the read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= mem_read & ack0;
      rvalid1 <= mem_read & ack1;
      if (mem_read && ack0) begin
        rdata0 <= mem_rdata;
      end
      if (mem_read && ack1) begin
        rdata1 <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: round-robin (u_rr) and fixed-priority (u_fx)
// instances share stimulus, each with its own behavioural 256x8 memory.
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, we0, req1, we1;
  logic [7:0] addr0, wdata0, addr1, wdata1;

  logic       a_ack0, a_ack1, a_rvalid0, a_rvalid1, a_stall0, a_mem_write, a_mem_read;
  logic [7:0] a_rdata0, a_rdata1, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic       b_ack0, b_ack1, b_rvalid0, b_rvalid1, b_stall0, b_mem_write, b_mem_read;
  logic [7:0] b_rdata0, b_rdata1, b_mem_addr, b_mem_wdata, b_mem_rdata;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.FIXED_PRI(0), .AW(8), .DW(8)) u_rr (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(a_ack0), .ack1(a_ack1), .rvalid0(a_rvalid0), .rvalid1(a_rvalid1),
    .rdata0(a_rdata0), .rdata1(a_rdata1), .stall0(a_stall0),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_write(a_mem_write),
    .mem_read(a_mem_read), .mem_rdata(a_mem_rdata)
  );

  dmem_arbiter #(.FIXED_PRI(1), .AW(8), .DW(8)) u_fx (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(b_ack0), .ack1(b_ack1), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1),
    .rdata0(b_rdata0), .rdata1(b_rdata1), .stall0(b_stall0),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_write(b_mem_write),
    .mem_read(b_mem_read), .mem_rdata(b_mem_rdata)
  );

  // Memories: write on posedge, read on negedge.
  always @(posedge clk) begin
    if (a_mem_write) mem_a[a_mem_addr] = a_mem_wdata;
    if (b_mem_write) mem_b[b_mem_addr] = b_mem_wdata;
  end

  always @(negedge clk) begin
    if (a_mem_read) a_mem_rdata <= mem_a[a_mem_addr];
    if (b_mem_read) b_mem_rdata <= mem_b[b_mem_addr];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle checks: exclusivity invariants and scoreboard pops for u_rr.
  task automatic sample();
    logic [7:0] e;
    chk("ack_excl_rr", 32'(a_ack0 & a_ack1), 0);
    chk("ack_excl_fx", 32'(b_ack0 & b_ack1), 0);
    chk("rvalid_excl_rr", 32'(a_rvalid0 & a_rvalid1), 0);
    chk("rw_excl_rr", 32'(a_mem_read & a_mem_write), 0);
    if (a_rvalid0) begin
      if (q0.size() == 0) chk("rvalid0_unexpected", 32'(a_rvalid0), 0);
      else begin
        e = q0.pop_front();
        chk("rdata0_sb", 32'(a_rdata0), 32'(e));
      end
    end
    if (a_rvalid1) begin
      if (q1.size() == 0) chk("rvalid1_unexpected", 32'(a_rvalid1), 0);
      else begin
        e = q1.pop_front();
        chk("rdata1_sb", 32'(a_rdata1), 32'(e));
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    sample();
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // One single-port transaction with latency/strobe checks; returns in the
  // cycle after the ack, with the request already dropped.
  task automatic issue(input logic p, input logic w, input logic [7:0] a,
                       input logic [7:0] d, input logic [7:0] exp);
    int lat;
    logic got;
    if (!p) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    else    begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    got = 1'b0;
    lat = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      cyc();
      if (p ? a_ack1 : a_ack0) begin got = 1'b1; lat = k; end
    end
    if (!got) begin
      chk("ack_timeout", 32'(got), 1);
      req0 = 1'b0;
      req1 = 1'b0;
    end else begin
      chk("ack_latency", 32'(lat), 0);
      chk("fx_ack", 32'(p ? b_ack1 : b_ack0), 1);
      chk("mem_write", 32'(a_mem_write), 32'(w));
      chk("mem_read", 32'(a_mem_read), 32'(!w));
      chk("mem_addr", 32'(a_mem_addr), 32'(a));
      if (w) chk("mem_wdata", 32'(a_mem_wdata), 32'(d));
      if (!p) req0 = 1'b0; else req1 = 1'b0;
      if (!w) begin
        if (!p) q0.push_back(exp); else q1.push_back(exp);
      end
      cyc();
      if (!w) chk("rvalid_latency", 32'(p ? a_rvalid1 : a_rvalid0), 1);
      chk("idle_strobes", 32'({a_mem_write, a_mem_read}), 0);
    end
  endtask

  typedef struct {
    logic       p;
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t tv [12];
  int   pat_rr [4];

  initial begin
    tv[0]  = '{1'b0, 1'b0, 8'd100, 8'h00, 8'h01};
    tv[1]  = '{1'b1, 1'b1, 8'd200, 8'hA5, 8'h00};
    tv[2]  = '{1'b1, 1'b0, 8'd200, 8'h00, 8'hA5};
    tv[3]  = '{1'b0, 1'b1, 8'd0,   8'h5A, 8'h00};
    tv[4]  = '{1'b1, 1'b0, 8'd0,   8'h00, 8'h5A};
    tv[5]  = '{1'b1, 1'b1, 8'd255, 8'hC3, 8'h00};
    tv[6]  = '{1'b0, 1'b0, 8'd255, 8'h00, 8'hC3};
    tv[7]  = '{1'b0, 1'b1, 8'd255, 8'hFF, 8'h00};
    tv[8]  = '{1'b0, 1'b0, 8'd255, 8'h00, 8'hFF};
    tv[9]  = '{1'b1, 1'b0, 8'd101, 8'h00, 8'h02};
    tv[10] = '{1'b0, 1'b1, 8'd7,   8'h81, 8'h00};
    tv[11] = '{1'b1, 1'b0, 8'd7,   8'h00, 8'h81};
    pat_rr = '{0, 1, 0, 1};

    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'h00;
    end
    mem_a[100] = 8'd1; mem_a[101] = 8'd2; mem_a[102] = 8'd4;
    mem_b[100] = 8'd1; mem_b[101] = 8'd2; mem_b[102] = 8'd4;

    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    rst  = 1'b1;
    cyc();
    do_reset();

    // Reset state
    chk("rst_acks", 32'({a_ack0, a_ack1, b_ack0, b_ack1}), 0);
    chk("rst_rvalid", 32'({a_rvalid0, a_rvalid1}), 0);
    chk("rst_strobes", 32'({a_mem_write, a_mem_read}), 0);
    chk("rst_addr", 32'(a_mem_addr), 0);
    chk("rst_wdata", 32'(a_mem_wdata), 0);
    chk("rst_rdata", 32'({a_rdata0, a_rdata1}), 0);
    chk("rst_stall0", 32'(a_stall0), 0);

    // Single read from port 0: stall only while pending
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'd100;
    #1;
    chk("t1_stall_c1", 32'(a_stall0), 1);
    chk("t1_ack_c1", 32'(a_ack0), 0);
    cyc();
    chk("t1_ack_c2", 32'(a_ack0), 1);
    chk("t1_read_c2", 32'(a_mem_read), 1);
    chk("t1_addr_c2", 32'(a_mem_addr), 100);
    chk("t1_stall_c2", 32'(a_stall0), 0);
    req0 = 1'b0;
    q0.push_back(8'd1);
    cyc();
    chk("t1_rvalid_c3", 32'(a_rvalid0), 1);
    chk("t1_rdata_c3", 32'(a_rdata0), 1);
    cyc();
    chk("t1_rvalid_c4", 32'(a_rvalid0), 0);
    chk("t1_rdata_hold", 32'(a_rdata0), 1);

    // Port 1 write then read of the same address
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'd200; wdata1 = 8'hA5;
    cyc();
    chk("t2_ack_c2", 32'(a_ack1), 1);
    chk("t2_write_c2", 32'(a_mem_write), 1);
    req1 = 1'b0;
    cyc();
    chk("t2_write_c3", 32'(a_mem_write), 0);
    req1 = 1'b1; we1 = 1'b0;
    cyc();
    chk("t2_ack_c4", 32'(a_ack1), 1);
    chk("t2_write_c4", 32'(a_mem_write), 0);
    req1 = 1'b0;
    q1.push_back(8'hA5);
    cyc();
    chk("t2_rvalid_c5", 32'(a_rvalid1), 1);
    chk("t2_rdata_c5", 32'(a_rdata1), 32'hA5);
    cyc();

    // Both ports held from c1: alternate every cycle in both modes
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'd101;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'd102;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("t3_rr_ack0", 32'(a_ack0), 32'(pat_rr[k] == 0));
      chk("t3_rr_ack1", 32'(a_ack1), 32'(pat_rr[k] == 1));
      chk("t4_fx_ack0", 32'(b_ack0), 32'(pat_rr[k] == 0));
      chk("t4_fx_ack1", 32'(b_ack1), 32'(pat_rr[k] == 1));
      if (pat_rr[k] == 0) q0.push_back(8'd2); else q1.push_back(8'd4);
      if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
    end
    cyc();
    cyc();
    chk("t3_rdata0", 32'(a_rdata0), 2);
    chk("t3_rdata1", 32'(a_rdata1), 4);
    chk("t4_rdata0", 32'(b_rdata0), 2);
    chk("t4_rdata1", 32'(b_rdata1), 4);

    // After a port 0 grant, round-robin favours port 1; fixed favours port 0
    do_reset();
    issue(1'b0, 1'b0, 8'd101, 8'h00, 8'd2);
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'd101;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'd102;
    cyc();
    chk("rr_pick1", 32'({a_ack0, a_ack1}), 32'b01);
    chk("fx_pick0", 32'({b_ack0, b_ack1}), 32'b10);
    q1.push_back(8'd4);
    cyc();
    chk("rr_pick0", 32'({a_ack0, a_ack1}), 32'b10);
    chk("fx_pick1", 32'({b_ack0, b_ack1}), 32'b01);
    q0.push_back(8'd2);
    req0 = 1'b0; req1 = 1'b0;
    cyc();
    cyc();

    // Reset at the end of a write's issue cycle
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'd150; wdata0 = 8'd7;
    cyc();
    chk("t5_ack", 32'(a_ack0), 1);
    chk("t5_write", 32'(a_mem_write), 1);
    rst = 1'b1;
    req0 = 1'b0;
    cyc();
    chk("t5_mem_rr", 32'(mem_a[150]), 7);
    chk("t5_mem_fx", 32'(mem_b[150]), 7);
    chk("t5_acks", 32'({a_ack0, a_ack1}), 0);
    chk("t5_rvalid", 32'({a_rvalid0, a_rvalid1}), 0);
    chk("t5_strobes", 32'({a_mem_write, a_mem_read}), 0);
    chk("t5_addr", 32'(a_mem_addr), 0);
    chk("t5_wdata", 32'(a_mem_wdata), 0);
    chk("t5_rdata", 32'({a_rdata0, a_rdata1}), 0);
    chk("t5_stall", 32'(a_stall0), 0);
    rst = 1'b0;
    cyc();
    chk("t5_no_ack", 32'({a_ack0, a_ack1, b_ack0, b_ack1}), 0);

    // Reset while a read is in flight
    issue(1'b0, 1'b0, 8'd101, 8'h00, 8'd2);
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'd100;
    cyc();
    chk("t6_ack", 32'(a_ack0), 1);
    chk("t6_read", 32'(a_mem_read), 1);
    rst = 1'b1;
    req0 = 1'b0;
    cyc();
    chk("t6_rvalid", 32'(a_rvalid0), 0);
    chk("t6_read_off", 32'(a_mem_read), 0);
    chk("t6_rdata_clr", 32'(a_rdata0), 0);
    rst = 1'b0;
    cyc();
    chk("t6_rvalid_after", 32'(a_rvalid0), 0);

    // Write on port 0 followed in the next cycle by a read on port 1
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'd50; wdata0 = 8'h66;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'd50;
    cyc();
    chk("raw_w_ack", 32'({a_ack0, a_mem_write}), 32'b11);
    req0 = 1'b0;
    cyc();
    chk("raw_r_ack", 32'({a_ack1, a_mem_read}), 32'b11);
    req1 = 1'b0;
    q1.push_back(8'h66);
    cyc();
    chk("raw_rdata_rr", 32'(a_rdata1), 32'h66);
    chk("raw_rdata_fx", 32'(b_rdata1), 32'h66);
    cyc();

    // Table of single-port transactions
    for (int i = 0; i < 12; i++) begin
      issue(tv[i].p, tv[i].w, tv[i].a, tv[i].d, tv[i].exp);
    end
    cyc();
    cyc();
    chk("sb_drained", 32'(q0.size() + q1.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
